// File: rtl/periph_pkg.sv
// Shared constants for the peripheral bus: register offsets, TCON bit positions
// and the default peripheral window base.
package periph_pkg;

    localparam int DATA_W = 32;
    localparam int OFF_W  = 3;

    localparam logic [DATA_W-1:0] PERIPH_BASE_DEFAULT = 32'h4000_0000;

    localparam logic [OFF_W-1:0] OFF_TH      = 3'd0;
    localparam logic [OFF_W-1:0] OFF_TL      = 3'd1;
    localparam logic [OFF_W-1:0] OFF_TCON    = 3'd2;
    localparam logic [OFF_W-1:0] OFF_LEDS    = 3'd3;
    localparam logic [OFF_W-1:0] OFF_DIGI    = 3'd4;
    localparam logic [OFF_W-1:0] OFF_SYSTICK = 3'd5;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IS = 2;

    localparam logic [DATA_W-1:0] TL_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        REGION_NONE  = 2'd0,
        REGION_RAM   = 2'd1,
        REGION_PERIF = 2'd2
    } region_t;

    // Zero-extends a narrow register field onto the 32-bit read bus.
    function automatic logic [DATA_W-1:0] zext12(input logic [11:0] v);
        return {{(DATA_W-12){1'b0}}, v};
    endfunction

endpackage

// File: rtl/periph_timer.sv
// Interval timer: TL counts up while enabled, reloads from TH after reaching all
// ones, and latches an interrupt status bit that only a CPU write can clear.
module periph_timer
    import periph_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [OFF_W-1:0]  wr_off,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] th,
    output logic [DATA_W-1:0] tl,
    output logic [2:0]        tcon,
    output logic              irq
);

    logic wr_th;
    logic wr_tl;
    logic wr_tcon;
    logic wrap;
    logic irq_set;

    assign wr_th   = wr_en && (wr_off == OFF_TH);
    assign wr_tl   = wr_en && (wr_off == OFF_TL);
    assign wr_tcon = wr_en && (wr_off == OFF_TCON);

    assign wrap    = tcon[TCON_EN] && (tl == TL_MAX);
    assign irq_set = wrap && tcon[TCON_IE];

    always_ff @(posedge clk) begin
        if (!reset) begin
            th   <= '0;
            tl   <= '0;
            tcon <= '0;
        end else begin
            if (wr_th)
                th <= wr_data;

            // A CPU write to TL wins over both increment and reload; reload uses
            // the TH value from before this edge.
            if (wr_tl)
                tl <= wr_data;
            else if (wrap)
                tl <= th;
            else if (tcon[TCON_EN])
                tl <= tl + 32'd1;

            // The hardware set is OR'd into a CPU write so an overflow is never lost.
            if (wr_tcon) begin
                tcon[TCON_EN] <= wr_data[TCON_EN];
                tcon[TCON_IE] <= wr_data[TCON_IE];
                tcon[TCON_IS] <= wr_data[TCON_IS] | irq_set;
            end else if (irq_set) begin
                tcon[TCON_IS] <= 1'b1;
            end
        end
    end

    assign irq = tcon[TCON_IS];

endmodule

// File: rtl/periph_bus.sv
// Load/store bus stage: decodes RAM vs peripheral window, hosts leds/digi/systick,
// muxes read data and instantiates the interval timer.
module periph_bus
    import periph_pkg::*;
#(
    parameter int                RAM_SIZE_BIT = 8,
    parameter logic [DATA_W-1:0] PERIPH_BASE  = PERIPH_BASE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [DATA_W-1:0] Address,
    input  logic [DATA_W-1:0] Write_data,
    output logic [DATA_W-1:0] Read_data,
    output logic              ram_MemRead,
    output logic              ram_MemWrite,
    input  logic [DATA_W-1:0] ram_Read_data,
    output logic [7:0]        leds,
    output logic [11:0]       digi,
    output logic              irq
);

    region_t           region;
    logic [OFF_W-1:0]  offset;
    logic              perif_wr;
    logic [DATA_W-1:0] systick;
    logic [DATA_W-1:0] th;
    logic [DATA_W-1:0] tl;
    logic [2:0]        tcon;
    logic [DATA_W-1:0] perif_rdata;
    logic              unused_byte_sel;

    // Only word accesses exist; the byte-select bits carry no meaning here.
    assign unused_byte_sel = ^Address[1:0];

    always_comb begin
        region = REGION_NONE;
        if (Address[DATA_W-1:RAM_SIZE_BIT+2] == '0)
            region = REGION_RAM;
        else if (Address[DATA_W-1:5] == PERIPH_BASE[DATA_W-1:5])
            region = REGION_PERIF;
    end

    assign offset       = Address[4:2];
    assign ram_MemRead  = MemRead  && (region == REGION_RAM);
    assign ram_MemWrite = MemWrite && (region == REGION_RAM);
    assign perif_wr     = MemWrite && (region == REGION_PERIF);

    always_ff @(posedge clk) begin
        if (!reset) begin
            leds    <= '0;
            digi    <= '0;
            systick <= '0;
        end else begin
            systick <= systick + 32'd1;
            if (perif_wr && offset == OFF_LEDS)
                leds <= Write_data[7:0];
            if (perif_wr && offset == OFF_DIGI)
                digi <= Write_data[11:0];
        end
    end

    periph_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (perif_wr),
        .wr_off  (offset),
        .wr_data (Write_data),
        .th      (th),
        .tl      (tl),
        .tcon    (tcon),
        .irq     (irq)
    );

    always_comb begin
        perif_rdata = '0;
        case (offset)
            OFF_TH:      perif_rdata = th;
            OFF_TL:      perif_rdata = tl;
            OFF_TCON:    perif_rdata = {29'd0, tcon};
            OFF_LEDS:    perif_rdata = {24'd0, leds};
            OFF_DIGI:    perif_rdata = zext12(digi);
            OFF_SYSTICK: perif_rdata = systick;
            default:     perif_rdata = '0;
        endcase
    end

    always_comb begin
        Read_data = '0;
        if (MemRead) begin
            case (region)
                REGION_RAM:   Read_data = ram_Read_data;
                REGION_PERIF: Read_data = perif_rdata;
                default:      Read_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_periph_bus.sv
// Directed bench for periph_bus with a small RAM model behind the memory port.
module tb_periph_bus;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic [31:0] Read_data;
    logic        ram_MemRead;
    logic        ram_MemWrite;
    logic [31:0] ram_Read_data;
    logic [7:0]  leds;
    logic [11:0] digi;
    logic        irq;

    logic [31:0] mem [0:255];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] rdata;
    logic        strobe;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_LEDS = 32'h4000_000C;
    localparam logic [31:0] A_DIGI = 32'h4000_0010;
    localparam logic [31:0] A_TICK = 32'h4000_0014;
    localparam logic [31:0] A_RSV  = 32'h4000_0018;

    periph_bus dut (
        .clk           (clk),
        .reset         (reset),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .Address       (Address),
        .Write_data    (Write_data),
        .Read_data     (Read_data),
        .ram_MemRead   (ram_MemRead),
        .ram_MemWrite  (ram_MemWrite),
        .ram_Read_data (ram_Read_data),
        .leds          (leds),
        .digi          (digi),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (ram_MemWrite) mem[Address[9:2]] <= Write_data;
    assign ram_Read_data = mem[Address[9:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Store across one posedge; strobe captures ram_MemWrite during the access.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Address = a; Write_data = d; MemWrite = 1'b1;
        #1 strobe = ram_MemWrite;
        @(negedge clk);
        MemWrite = 1'b0; Address = 32'h0; Write_data = 32'h0;
    endtask

    // Zero-latency load between edges; strobe captures ram_MemRead.
    task automatic rd(input logic [31:0] a);
        Address = a; MemRead = 1'b1;
        #1 rdata = Read_data; strobe = ram_MemRead;
        MemRead = 1'b0; Address = 32'h0;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        Address = 32'h0; Write_data = 32'h0;
        repeat (2) cyc();

        chk("rst_leds", {24'd0, leds}, 32'h0);
        chk("rst_digi", {20'd0, digi}, 32'h0);
        chk("rst_irq", {31'd0, irq}, 32'h0);
        rd(A_TICK); chk("rst_systick", rdata, 32'h0);
        rd(A_TCON); chk("rst_tcon", rdata, 32'h0);

        // systick: ten edges after release
        reset = 1'b1;
        repeat (10) cyc();
        rd(A_TICK); chk("systick_10", rdata, 32'd10);
        wr(A_TICK, 32'h0);
        rd(A_TICK); chk("systick_ro", rdata, 32'd11);

        // RAM store/load
        wr(32'h0000_0010, 32'h1234_5678);
        chk("ram_wr_strobe", {31'd0, strobe}, 32'd1);
        #1 chk("ram_wr_idle", {31'd0, ram_MemWrite}, 32'd0);
        rd(32'h0000_0010);
        chk("ram_rd_data", rdata, 32'h1234_5678);
        chk("ram_rd_strobe", {31'd0, strobe}, 32'd1);
        Address = A_LEDS; #1;
        chk("noread_zero", Read_data, 32'h0);
        cyc();

        // peripheral registers
        wr(A_LEDS, 32'hFFFF_FFA5);
        chk("leds_wr", {24'd0, leds}, 32'hA5);
        wr(A_DIGI, 32'hFFFF_F5A3);
        chk("digi_wr", {20'd0, digi}, 32'h5A3);
        rd(A_DIGI); chk("digi_rd", rdata, 32'h5A3);
        chk("perif_no_ram_rd", {31'd0, strobe}, 32'd0);

        // unmapped and reserved
        wr(32'h0000_0400, 32'hDEAD_BEEF);
        chk("unmap_wr_strobe", {31'd0, strobe}, 32'd0);
        rd(32'h0000_0400);
        chk("unmap_rd_data", rdata, 32'h0);
        chk("unmap_rd_strobe", {31'd0, strobe}, 32'd0);
        wr(A_RSV, 32'hFFFF_FFFF);
        chk("rsv_wr_strobe", {31'd0, strobe}, 32'd0);
        rd(A_RSV); chk("rsv_rd", rdata, 32'h0);
        chk("rsv_leds", {24'd0, leds}, 32'hA5);
        chk("rsv_digi", {20'd0, digi}, 32'h5A3);
        rd(A_TH); chk("rsv_th", rdata, 32'h0);
        rd(A_TCON); chk("rsv_tcon", rdata, 32'h0);

        // timer reload and interrupt
        wr(A_TH, 32'hFFFF_FFFD);
        wr(A_TL, 32'hFFFF_FFFE);
        wr(A_TCON, 32'h3);
        rd(A_TL); chk("tmr_tl_start", rdata, 32'hFFFF_FFFE);
        cyc();
        rd(A_TL); chk("tmr_tl_max", rdata, 32'hFFFF_FFFF);
        chk("tmr_irq_low", {31'd0, irq}, 32'd0);
        cyc();
        rd(A_TL); chk("tmr_reload", rdata, 32'hFFFF_FFFD);
        chk("tmr_irq_rise", {31'd0, irq}, 32'd1);
        rd(A_TCON); chk("tmr_tcon", rdata, 32'h7);
        cyc();
        chk("tmr_irq_hold", {31'd0, irq}, 32'd1);

        // clear coinciding with overflow, then a clean clear
        cyc();
        rd(A_TL); chk("clr_tl_max", rdata, 32'hFFFF_FFFF);
        wr(A_TCON, 32'h3);
        chk("clr_vs_ovf_irq", {31'd0, irq}, 32'd1);
        rd(A_TL); chk("clr_vs_ovf_tl", rdata, 32'hFFFF_FFFD);
        wr(A_TCON, 32'h3);
        chk("clr_irq_fall", {31'd0, irq}, 32'd0);

        // CPU write beats increment
        wr(A_TL, 32'h5);
        rd(A_TL); chk("prio_tl5", rdata, 32'h5);
        cyc();
        rd(A_TL); chk("prio_tl6", rdata, 32'h6);

        // reset mid-count
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        rd(A_TL); chk("mrst_tl", rdata, 32'h0);
        rd(A_TCON); chk("mrst_tcon", rdata, 32'h0);
        rd(A_TICK); chk("mrst_systick", rdata, 32'h0);
        chk("mrst_irq", {31'd0, irq}, 32'd0);
        chk("mrst_leds", {24'd0, leds}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/periph_bus.md
Name: periph_bus

Overview:
- Memory-mapped bus stage between the CPU datapath's load/store port and the data memory.
- Decodes each access:
  - RAM-region accesses are forwarded to the data memory.
  - Peripheral-region accesses are served locally by an interval timer, LED register, 7-segment register and free-running systick counter.
- Returns the muxed read data to the datapath and raises a timer interrupt request for the control unit.

Parameters:
- RAM_SIZE_BIT, 8, word-address bits of data memory; the RAM region is bytes 0 .. 4*2^RAM_SIZE_BIT-1.
- PERIPH_BASE, 32'h40000000, base byte address of the peripheral window.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset; sampled on posedge clk.
- MemRead  input  1  CPU load strobe.
- MemWrite  input  1  CPU store strobe.
- Address  input  32  CPU byte address.
- Write_data  input  32  CPU store data.
- Read_data  output  32  load data returned to CPU (combinational).
- ram_MemRead  output  1  read strobe to data memory.
- ram_MemWrite  output  1  write strobe to data memory.
- ram_Read_data  input  32  data memory read data.
- leds  output  8  LED register.
- digi  output  12  7-segment register: [11:8] anode select, [7:0] segments.
- irq  output  1  timer interrupt request; equals TCON[2].

Behaviour:
- Decode, combinational:
  - RAM region: Address[31:RAM_SIZE_BIT+2]==0.
  - PERIF region: Address[31:5]==PERIPH_BASE[31:5].
  - Anything else is unmapped.
- ram_MemRead = MemRead & RAM region; ram_MemWrite = MemWrite & RAM region. Address and Write_data go to the memory unmodified.
- Register map, offset = Address[4:2]:
  - 0: TH, rw, 32 bits.
  - 1: TL, rw, 32 bits.
  - 2: TCON, rw, 3 bits: [0] enable, [1] irq enable, [2] irq status.
  - 3: leds, rw, 8 bits.
  - 4: digi, rw, 12 bits.
  - 5: systick, ro, 32 bits.
  - 6 and 7: reserved; read 0, writes ignored.
- Address[1:0] is ignored; only word accesses are supported.
- Read_data:
  - MemRead=0: 32'h0.
  - RAM region: ram_Read_data.
  - PERIF region: selected register, zero-extended.
  - Unmapped: 32'h0.
  - Zero latency; the value reflects state before the current clock edge.
- Writes take effect on the posedge where MemWrite=1 and the decode hits. Writes to systick, reserved or unmapped addresses are dropped.
- Reset (reset=0 at posedge): TH=TL=0, TCON=0, leds=0, digi=0, systick=0, so irq=0. Reset overrides all same-cycle writes and counting. Reset mid-count discards the count.
- systick increments by 1 every cycle out of reset and wraps from 32'hFFFFFFFF to 0.
- Timer, evaluated each posedge when TCON[0]=1:
  - TL!=32'hFFFFFFFF: TL<=TL+1.
  - TL==32'hFFFFFFFF: TL<=TH; if TCON[1]=1, TCON[2]<=1.
  - TCON[0]=0: TL holds.
- Simultaneous events, same edge:
  - CPU write to TL beats the timer increment or reload.
  - CPU write to TH does not affect a reload on that edge; the reload uses the old TH.
  - CPU write to TCON sets bits [1:0] from Write_data. Bit[2] <= Write_data[2], OR'd with a hardware overflow set on that edge, so an interrupt is never lost.
  - TCON[2] clears only via a CPU write with bit2=0 (and no coincident overflow).
- Changing TCON[1] does not alter an already-set TCON[2].
- irq is registered state (TCON[2]), with no combinational path from the inputs.

Decomposition:
- Shared package, periph_pkg:
  - Register offset constants: OFF_TH, OFF_TL, OFF_TCON, OFF_LEDS, OFF_DIGI, OFF_SYSTICK.
  - TCON bit indices: TCON_EN=0, TCON_IE=1, TCON_IS=2.
  - PERIPH_BASE default.
- One natural sub-module, periph_timer: TH/TL/TCON state, the overflow/reload logic and irq, with a write-enable/offset/data input.
- Decode, leds/digi/systick registers and the read mux stay in periph_bus.

Test Plan:
- Reset, then RAM store/load:
  - Stimulus: hold reset=0 for 2 cycles, release, store 32'h12345678 at 0x00000010, then load it.
  - Required: ram_MemWrite=1 only on the store cycle; the load returns ram_Read_data; leds=0, digi=0, irq=0 after reset.
- Unmapped and boundary decode:
  - Stimulus: access 0x00000400 (first byte above RAM) and 0x40000018 (reserved offset).
  - Required: ram strobes are 0 for both; reads return 0; writes change no state.
- Timer reload and interrupt:
  - Stimulus: TH=32'hFFFFFFFD, TL=32'hFFFFFFFE, TCON=3'b011.
  - Required: TL goes FFFFFFFF, then FFFFFFFD on the next edge; irq rises in the same cycle TL shows FFFFFFFD; irq stays high.
- Interrupt clear vs overflow:
  - Stimulus: write TCON=3'b011 on the exact edge where TL==FFFFFFFF.
  - Required: TCON[2] stays 1 and irq stays high.
  - Stimulus: the same write one cycle later.
  - Required: irq falls.
- CPU write priority:
  - Stimulus: timer enabled; write TL=32'h00000005 on an increment edge.
  - Required: TL reads 5 the next cycle and 6 the cycle after.
- systick:
  - Stimulus: read systick 10 cycles after reset release, then write 32'h0 to it.
  - Required: the read value is 10; the write is ignored and the count continues.
- Mid-count reset:
  - Stimulus: pulse reset=0 while the timer is counting.
  - Required: TL=0, TCON=0, systick=0 on the next cycle.
